// File: rtl/axi4_burst_mem_slave.sv
// AXI4 burst memory slave for simulation.
// Independent read and write FSMs, FIXED/INCR/WRAP address generation,
// per-burst OKAY/SLVERR responses and a write-only byte mailbox.
// The backing store is a byte array indexed by the low MEM_AW address bits,
// so addresses that differ only above MEM_AW alias onto the same bytes.
module axi4_burst_mem_slave #(
  parameter int          TAGW         = 4,
  parameter int          DW           = 64,
  parameter int          RD_LAT       = 1,
  parameter logic [31:0] MAILBOX_ADDR = 32'hD0580000,
  parameter int          MEM_AW       = 16
) (
  input  logic              aclk,
  input  logic              rst_l,
  // read address channel
  input  logic              arvalid,
  output logic              arready,
  input  logic [31:0]       araddr,
  input  logic [TAGW-1:0]   arid,
  input  logic [7:0]        arlen,
  input  logic [1:0]        arburst,
  input  logic [2:0]        arsize,
  // read data channel
  output logic              rvalid,
  input  logic              rready,
  output logic [DW-1:0]     rdata,
  output logic [1:0]        rresp,
  output logic [TAGW-1:0]   rid,
  output logic              rlast,
  // write address channel
  input  logic              awvalid,
  output logic              awready,
  input  logic [31:0]       awaddr,
  input  logic [TAGW-1:0]   awid,
  input  logic [7:0]        awlen,
  input  logic [1:0]        awburst,
  input  logic [2:0]        awsize,
  // write data channel
  input  logic              wvalid,
  output logic              wready,
  input  logic [DW-1:0]     wdata,
  input  logic [DW/8-1:0]   wstrb,
  input  logic              wlast,
  // write response channel
  output logic              bvalid,
  input  logic              bready,
  output logic [1:0]        bresp,
  output logic [TAGW-1:0]   bid,
  // mailbox
  output logic              mbox_valid,
  output logic [7:0]        mbox_data
);

  localparam int NB  = DW / 8;
  localparam int LSB = $clog2(NB);
  localparam int LCW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [LCW-1:0] LAT_LAST = LCW'(RD_LAT - 1);

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [1:0] R_IDLE = 2'd0;
  localparam logic [1:0] R_WAIT = 2'd1;
  localparam logic [1:0] R_DATA = 2'd2;

  localparam logic [1:0] W_IDLE = 2'd0;
  localparam logic [1:0] W_DATA = 2'd1;
  localparam logic [1:0] W_RESP = 2'd2;

  // Address of the beat following 'addr' for the given burst shape.
  function automatic logic [31:0] next_addr(input logic [31:0] addr,
                                            input logic [7:0]  len,
                                            input logic [2:0]  size,
                                            input logic [1:0]  burst);
    logic [31:0] bytes;
    logic [31:0] total;
    logic [31:0] mask;
    bytes = 32'd1 << size;
    total = ({24'd0, len} + 32'd1) << size;
    mask  = total - 32'd1;
    case (burst)
      BURST_INCR: next_addr = addr + bytes;
      BURST_WRAP: next_addr = (addr & ~mask) | ((addr + bytes) & mask);
      default:    next_addr = addr;
    endcase
  endfunction

  // FIXED and INCR are always legal; WRAP only with 2/4/8/16 beats.
  function automatic logic burst_ok(input logic [7:0] len,
                                    input logic [1:0] burst);
    case (burst)
      BURST_FIXED, BURST_INCR: burst_ok = 1'b1;
      BURST_WRAP: burst_ok = (len == 8'd1) || (len == 8'd3) ||
                             (len == 8'd7) || (len == 8'd15);
      default:    burst_ok = 1'b0;
    endcase
  endfunction

  // A beat occupies lanes (addr mod NB) upward, 2^size lanes, clipped to the bus.
  function automatic logic lane_en(input logic [31:0] addr,
                                   input logic [2:0]  size,
                                   input int          lane);
    int lo;
    int nbytes;
    lo      = int'(addr[LSB-1:0]);
    nbytes  = 1 << size;
    lane_en = (lane >= lo) && (lane < lo + nbytes);
  endfunction

  logic [7:0] mem [0:(2**MEM_AW)-1];

  // ---------------------------------------------------------------- read side
  logic [1:0]      r_state;
  logic [TAGW-1:0] r_id;
  logic [31:0]     r_addr;
  logic [7:0]      r_len;
  logic [2:0]      r_size;
  logic [1:0]      r_burst;
  logic [7:0]      r_cnt;
  logic            r_ok;
  logic [LCW-1:0]  lat_cnt;

  logic [31:0]     r_next_addr;
  logic [31:0]     load_addr;
  logic [DW-1:0]   load_data;

  assign r_next_addr = next_addr(r_addr, r_len, r_size, r_burst);
  // The first beat uses the latched address; later beats use the advanced one.
  assign load_addr   = (r_state == R_WAIT) ? r_addr : r_next_addr;

  // Gather the bytes of the beat about to be loaded onto their lanes.
  always_comb begin
    // NOTE: default every output of a combinational block first so no path leaves it unassigned (no latch).
    load_data = '0;
    for (int i = 0; i < NB; i++) begin
      if (r_ok && (load_addr != MAILBOX_ADDR) && lane_en(load_addr, r_size, i))
        load_data[8*i +: 8] = mem[{load_addr[MEM_AW-1:LSB], LSB'(i)}];
    end
  end

  // Read FSM: accept AR, wait out the latency, then stream beats.
  always_ff @(posedge aclk or negedge rst_l) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (!rst_l) begin
      r_state <= R_IDLE;
      arready <= 1'b1;
      rvalid  <= 1'b0;
      rlast   <= 1'b0;
      rdata   <= '0;
      rresp   <= RESP_OKAY;
      rid     <= '0;
      r_id    <= '0;
      r_addr  <= '0;
      r_len   <= '0;
      r_size  <= '0;
      r_burst <= '0;
      r_cnt   <= '0;
      r_ok    <= 1'b0;
      lat_cnt <= '0;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (arvalid && arready) begin
            r_id    <= arid;
            r_addr  <= araddr;
            r_len   <= arlen;
            r_size  <= arsize;
            r_burst <= arburst;
            r_ok    <= burst_ok(arlen, arburst);
            r_cnt   <= '0;
            lat_cnt <= '0;
            arready <= 1'b0;
            r_state <= R_WAIT;
          end
        end
        R_WAIT: begin
          if (lat_cnt == LAT_LAST) begin
            rvalid  <= 1'b1;
            rdata   <= load_data;
            rresp   <= r_ok ? RESP_OKAY : RESP_SLVERR;
            rid     <= r_id;
            rlast   <= (r_len == 8'd0);
            r_state <= R_DATA;
          end else begin
            lat_cnt <= lat_cnt + 1'b1;
          end
        end
        R_DATA: begin
          if (rready) begin
            if (rlast) begin
              rvalid  <= 1'b0;
              rlast   <= 1'b0;
              arready <= 1'b1;
              r_state <= R_IDLE;
            end else begin
              r_addr <= r_next_addr;
              r_cnt  <= r_cnt + 8'd1;
              rdata  <= load_data;
              rlast  <= ((r_cnt + 8'd1) == r_len);
            end
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

  // --------------------------------------------------------------- write side
  logic [1:0]      w_state;
  logic [TAGW-1:0] w_id;
  logic [31:0]     w_addr;
  logic [7:0]      w_len;
  logic [2:0]      w_size;
  logic [1:0]      w_burst;
  logic [7:0]      w_cnt;
  logic            w_ok;
  logic            w_bad_last;

  logic            w_hs;
  logic            w_is_last;
  logic            w_mbox_beat;

  assign w_hs        = wvalid && wready;
  assign w_is_last   = (w_cnt == w_len);
  assign w_mbox_beat = (w_addr == MAILBOX_ADDR);

  // Write FSM: accept AW, consume W beats, then hold the B response.
  always_ff @(posedge aclk or negedge rst_l) begin
    if (!rst_l) begin
      w_state    <= W_IDLE;
      awready    <= 1'b1;
      wready     <= 1'b0;
      bvalid     <= 1'b0;
      bresp      <= RESP_OKAY;
      bid        <= '0;
      w_id       <= '0;
      w_addr     <= '0;
      w_len      <= '0;
      w_size     <= '0;
      w_burst    <= '0;
      w_cnt      <= '0;
      w_ok       <= 1'b0;
      w_bad_last <= 1'b0;
    end else begin
      case (w_state)
        W_IDLE: begin
          if (awvalid && awready) begin
            w_id       <= awid;
            w_addr     <= awaddr;
            w_len      <= awlen;
            w_size     <= awsize;
            w_burst    <= awburst;
            w_ok       <= burst_ok(awlen, awburst);
            w_cnt      <= '0;
            w_bad_last <= 1'b0;
            awready    <= 1'b0;
            wready     <= 1'b1;
            w_state    <= W_DATA;
          end
        end
        W_DATA: begin
          if (w_hs) begin
            if (wlast != w_is_last)
              w_bad_last <= 1'b1;
            if (w_is_last) begin
              wready  <= 1'b0;
              bvalid  <= 1'b1;
              bid     <= w_id;
              bresp   <= (!w_ok || w_bad_last || (wlast != w_is_last)) ?
                         RESP_SLVERR : RESP_OKAY;
              w_state <= W_RESP;
            end else begin
              w_cnt  <= w_cnt + 8'd1;
              w_addr <= next_addr(w_addr, w_len, w_size, w_burst);
            end
          end
        end
        W_RESP: begin
          if (bready) begin
            bvalid  <= 1'b0;
            awready <= 1'b1;
            w_state <= W_IDLE;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  // Mailbox: one-cycle pulse carrying byte 0 of a beat aimed at MAILBOX_ADDR.
  always_ff @(posedge aclk or negedge rst_l) begin
    if (!rst_l) begin
      mbox_valid <= 1'b0;
      mbox_data  <= '0;
    end else begin
      mbox_valid <= w_hs && w_mbox_beat && wstrb[0];
      if (w_hs && w_mbox_beat && wstrb[0])
        mbox_data <= wdata[7:0];
    end
  end

  // Byte-lane memory write; mailbox beats and illegal bursts never reach storage.
  always_ff @(posedge aclk) begin
    // NOTE: the memory array is deliberately not reset so its contents survive rst_l.
    for (int i = 0; i < NB; i++) begin
      if (w_hs && w_ok && !w_mbox_beat && wstrb[i] && lane_en(w_addr, w_size, i))
        mem[{w_addr[MEM_AW-1:LSB], LSB'(i)}] <= wdata[8*i +: 8];
    end
  end

endmodule
